// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - single-byte SPI mode-0 master transfer sequencer
//
// Purpose: accepts a one-cycle START with a TX byte, runs one MSB-first
// mode-0 (CPOL=0, CPHA=0) byte exchange on the SPI pins and returns the
// received byte with a one-cycle DONE pulse.
//
// Parameters:
//   DIV       SCK half-period in ACLK cycles (1..255)
// Ports:
//   ACLK      system clock, rising edge
//   ARESETn   asynchronous active-low reset
//   START     transfer request, sampled only while idle
//   TX_DATA   byte to send, captured on the accepting edge
//   BUSY      high from accept edge until the DONE edge
//   DONE      one-cycle end-of-transfer pulse
//   RX_DATA   last received byte, updated only at DONE
//   SPI_SCK   serial clock, idles low
//   SPI_MOSI  serial data out, idles low
//   SPI_MISO  serial data in
//   SPI_SSn   active-low slave select, idles high
module spi_xfer_ctrl #(
  parameter int DIV = 4
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       START,
  input  logic [7:0] TX_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RX_DATA,
  output logic       SPI_SCK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic       SPI_SSn
);

  localparam int             CW       = $clog2(DIV + 1);
  localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          tick;

  // The divider only runs outside IDLE, so the first tick of a transfer
  // lands exactly DIV cycles after the accepting edge.
  assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      RX_DATA  <= '0;
      SPI_SCK  <= 1'b0;
      SPI_MOSI <= 1'b0;
      SPI_SSn  <= 1'b1;
    end else begin
      DONE <= 1'b0;

      if (state == IDLE || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          if (START) begin
            tx_sr    <= TX_DATA;
            SPI_MOSI <= TX_DATA[7];
            SPI_SSn  <= 1'b0;
            BUSY     <= 1'b1;
            bit_cnt  <= '0;
            state    <= SETUP;
          end
        end

        SETUP: begin
          // First rising SCK edge: MSB has had DIV cycles of setup.
          if (tick) begin
            SPI_SCK <= 1'b1;
            rx_sr   <= {rx_sr[6:0], SPI_MISO};
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (tick) begin
            SPI_SCK <= ~SPI_SCK;
            if (!SPI_SCK) begin
              rx_sr <= {rx_sr[6:0], SPI_MISO};
            end else if (bit_cnt != 3'd7) begin
              // MOSI only moves on falling SCK; next bit is tx_sr[6]
              // before the shift takes effect.
              tx_sr    <= {tx_sr[6:0], 1'b0};
              SPI_MOSI <= tx_sr[6];
              bit_cnt  <= bit_cnt + 3'd1;
            end else begin
              SPI_MOSI <= 1'b0;
              state    <= HOLD;
            end
          end
        end

        HOLD: begin
          if (tick) begin
            SPI_SSn <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            RX_DATA <= rx_sr;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - directed self-checking bench for spi_xfer_ctrl
module tb_spi_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // DIV=4 instance
  logic       start_a = 1'b0;
  logic [7:0] tx_a = 8'h00;
  logic       busy_a, done_a, sck_a, mosi_a, miso_a, ssn_a;
  logic [7:0] rx_a;

  // DIV=1 instance
  logic       start_b = 1'b0;
  logic [7:0] tx_b = 8'h00;
  logic       busy_b, done_b, sck_b, mosi_b, miso_b, ssn_b;
  logic [7:0] rx_b;

  // Slave model: presents bits of slave_byte MSB first, advancing on SCK fall
  logic       slave_mode = 1'b0;
  logic [7:0] slave_byte = 8'h3C;
  logic [2:0] slave_idx = 3'd7;

  int checks = 0;
  int failures = 0;

  bit       sck_t  [0:159];
  bit       ssn_t  [0:159];
  bit       done_t [0:159];
  bit       busy_t [0:159];
  bit       mosi_t [0:159];
  bit [7:0] rx_t   [0:159];

  always #5 clk = ~clk;

  assign miso_a = slave_mode ? slave_byte[slave_idx] : mosi_a;
  assign miso_b = mosi_b;

  always @(negedge sck_a or posedge ssn_a) begin
    if (ssn_a) slave_idx <= 3'd7;
    else       slave_idx <= slave_idx - 3'd1;
  end

  spi_xfer_ctrl #(.DIV(4)) dut_a (
    .ACLK(clk), .ARESETn(rst_n), .START(start_a), .TX_DATA(tx_a),
    .BUSY(busy_a), .DONE(done_a), .RX_DATA(rx_a), .SPI_SCK(sck_a),
    .SPI_MOSI(mosi_a), .SPI_MISO(miso_a), .SPI_SSn(ssn_a)
  );

  spi_xfer_ctrl #(.DIV(1)) dut_b (
    .ACLK(clk), .ARESETn(rst_n), .START(start_b), .TX_DATA(tx_b),
    .BUSY(busy_b), .DONE(done_b), .RX_DATA(rx_b), .SPI_SCK(sck_b),
    .SPI_MOSI(mosi_b), .SPI_MISO(miso_b), .SPI_SSn(ssn_b)
  );

  // Issues START on dut_a and records outputs after edges 0..ncyc.
  task automatic capture_a(input logic [7:0] tx, input logic [7:0] tx2,
                           input int ncyc, input bit hold, input int rel,
                           input int p1, input int p2);
    @(negedge clk);
    start_a = 1'b1;
    tx_a    = tx;
    @(posedge clk);
    for (int n = 0; n <= ncyc; n++) begin
      @(negedge clk);
      sck_t[n]  = sck_a;
      ssn_t[n]  = ssn_a;
      done_t[n] = done_a;
      busy_t[n] = busy_a;
      mosi_t[n] = mosi_a;
      rx_t[n]   = rx_a;
      if (n == 0) tx_a = tx2;
      if (n + 1 == p1 || n + 1 == p2) begin
        start_a = 1'b1;
        tx_a    = 8'hFF;
      end else if (!(hold && n < rel)) begin
        start_a = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_a); end
    checks++; if (rx_a !== 8'h00) begin failures++; $display("FAIL reset_rx got=%h exp=00", rx_a); end
    checks++; if (sck_a !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", sck_a); end
    checks++; if (mosi_a !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi_a); end
    checks++; if (ssn_a !== 1'b1) begin failures++; $display("FAIL reset_ssn got=%b exp=1", ssn_a); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback;
    int rises;
    int ndone;
    int ssn_bad;
    slave_mode = 1'b0;
    capture_a(8'hA5, 8'hA5, 75, 1'b0, 0, -1, -1);
    checks++; if (ssn_t[0] !== 1'b0 || busy_t[0] !== 1'b1 || mosi_t[0] !== 1'b1)
      begin failures++; $display("FAIL lb_edge0 got ssn=%b busy=%b mosi=%b exp 0 1 1", ssn_t[0], busy_t[0], mosi_t[0]); end
    rises = 0;
    for (int n = 1; n <= 75; n++) begin
      if (sck_t[n] && !sck_t[n-1]) begin
        checks++;
        if (n !== (2 * rises + 1) * 4) begin
          failures++; $display("FAIL lb_rise%0d got=%0d exp=%0d", rises, n, (2 * rises + 1) * 4);
        end
        rises++;
      end
    end
    checks++; if (rises !== 8) begin failures++; $display("FAIL lb_rises got=%0d exp=8", rises); end
    ssn_bad = 0;
    for (int n = 0; n < 68; n++) if (ssn_t[n] !== 1'b0) ssn_bad++;
    checks++; if (ssn_bad !== 0 || ssn_t[68] !== 1'b1)
      begin failures++; $display("FAIL lb_ssn low_violations=%0d ssn68=%b exp 0 1", ssn_bad, ssn_t[68]); end
    ndone = 0;
    for (int n = 0; n <= 75; n++) if (done_t[n]) ndone++;
    checks++; if (done_t[68] !== 1'b1 || ndone !== 1)
      begin failures++; $display("FAIL lb_done done68=%b count=%0d exp 1 1", done_t[68], ndone); end
    checks++; if (busy_t[67] !== 1'b1 || busy_t[68] !== 1'b0)
      begin failures++; $display("FAIL lb_busy b67=%b b68=%b exp 1 0", busy_t[67], busy_t[68]); end
    checks++; if (rx_t[68] !== 8'hA5) begin failures++; $display("FAIL lb_rx got=%h exp=a5", rx_t[68]); end
  endtask

  task automatic test_slave;
    logic [7:0] bits;
    bits = 8'h00;
    slave_mode = 1'b1;
    capture_a(8'hC3, 8'hC3, 70, 1'b0, 0, -1, -1);
    slave_mode = 1'b0;
    for (int n = 1; n <= 70; n++)
      if (sck_t[n] && !sck_t[n-1]) bits = {bits[6:0], mosi_t[n]};
    checks++; if (bits !== 8'hC3) begin failures++; $display("FAIL slave_mosi_bits got=%h exp=c3", bits); end
    checks++; if (rx_t[68] !== 8'h3C) begin failures++; $display("FAIL slave_rx got=%h exp=3c", rx_t[68]); end
    checks++; if (mosi_t[68] !== 1'b0) begin failures++; $display("FAIL slave_mosi_idle got=%b exp=0", mosi_t[68]); end
  endtask

  task automatic test_busy_ignore;
    int ndone;
    capture_a(8'h33, 8'h33, 80, 1'b0, 0, 5, 40);
    ndone = 0;
    for (int n = 0; n <= 80; n++) if (done_t[n]) ndone++;
    checks++; if (ndone !== 1 || done_t[68] !== 1'b1)
      begin failures++; $display("FAIL ignore_done count=%0d done68=%b exp 1 1", ndone, done_t[68]); end
    checks++; if (rx_t[80] !== 8'h33) begin failures++; $display("FAIL ignore_rx got=%h exp=33", rx_t[80]); end
    checks++; if (ssn_t[80] !== 1'b1 || busy_t[80] !== 1'b0)
      begin failures++; $display("FAIL ignore_idle ssn=%b busy=%b exp 1 0", ssn_t[80], busy_t[80]); end
  endtask

  task automatic test_back_to_back;
    int d0;
    int d1;
    int ndone;
    capture_a(8'h81, 8'h7E, 145, 1'b1, 69, -1, -1);
    d0 = -1; d1 = -1; ndone = 0;
    for (int n = 0; n <= 145; n++) begin
      if (done_t[n]) begin
        if (ndone == 0) d0 = n; else d1 = n;
        ndone++;
      end
    end
    checks++; if (ndone !== 2 || d0 !== 68 || d1 - d0 !== 69)
      begin failures++; $display("FAIL b2b_done count=%0d first=%0d second=%0d exp 2 68 137", ndone, d0, d1); end
    checks++; if (ssn_t[67] !== 1'b0 || ssn_t[68] !== 1'b1 || ssn_t[69] !== 1'b0)
      begin failures++; $display("FAIL b2b_ssn_gap s67=%b s68=%b s69=%b exp 0 1 0", ssn_t[67], ssn_t[68], ssn_t[69]); end
    checks++; if (busy_t[68] !== 1'b0 || busy_t[69] !== 1'b1 || done_t[69] !== 1'b0)
      begin failures++; $display("FAIL b2b_busy b68=%b b69=%b d69=%b exp 0 1 0", busy_t[68], busy_t[69], done_t[69]); end
    checks++; if (rx_t[68] !== 8'h81) begin failures++; $display("FAIL b2b_rx0 got=%h exp=81", rx_t[68]); end
    checks++; if (rx_t[137] !== 8'h7E) begin failures++; $display("FAIL b2b_rx1 got=%h exp=7e", rx_t[137]); end
    checks++; if (ssn_t[145] !== 1'b1) begin failures++; $display("FAIL b2b_third ssn=%b exp=1", ssn_t[145]); end
  endtask

  task automatic test_reset_mid;
    int ndone;
    @(negedge clk);
    start_a = 1'b1;
    tx_a    = 8'h96;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    checks++; if (sck_a !== 1'b1 || ssn_a !== 1'b0)
      begin failures++; $display("FAIL rstmid_pre sck=%b ssn=%b exp 1 0", sck_a, ssn_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (sck_a !== 1'b0 || ssn_a !== 1'b1 || busy_a !== 1'b0 || rx_a !== 8'h00 || mosi_a !== 1'b0)
      begin failures++; $display("FAIL rstmid_async sck=%b ssn=%b busy=%b rx=%h mosi=%b exp 0 1 0 00 0", sck_a, ssn_a, busy_a, rx_a, mosi_a); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL rstmid_nodone count=%0d exp=0", ndone); end
    capture_a(8'h5A, 8'h5A, 70, 1'b0, 0, -1, -1);
    checks++; if (done_t[68] !== 1'b1 || rx_t[68] !== 8'h5A)
      begin failures++; $display("FAIL rstmid_restart done=%b rx=%h exp 1 5a", done_t[68], rx_t[68]); end
  endtask

  task automatic test_div1;
    int bad_sck;
    int bad_done;
    @(negedge clk);
    start_b = 1'b1;
    tx_b    = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    tx_b    = 8'hF0;
    checks++; if (ssn_b !== 1'b0 || busy_b !== 1'b1 || mosi_b !== 1'b0)
      begin failures++; $display("FAIL div1_edge0 ssn=%b busy=%b mosi=%b exp 0 1 0", ssn_b, busy_b, mosi_b); end
    bad_sck = 0;
    bad_done = 0;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n <= 16 && sck_b !== n[0]) bad_sck++;
      if (n < 17 && done_b !== 1'b0) bad_done++;
      if (n == 17) begin
        checks++; if (done_b !== 1'b1 || busy_b !== 1'b0 || ssn_b !== 1'b1)
          begin failures++; $display("FAIL div1_done done=%b busy=%b ssn=%b exp 1 0 1", done_b, busy_b, ssn_b); end
        checks++; if (rx_b !== 8'h0F) begin failures++; $display("FAIL div1_rx got=%h exp=0f", rx_b); end
      end
    end
    checks++; if (bad_sck !== 0) begin failures++; $display("FAIL div1_sck_toggle bad=%0d exp=0", bad_sck); end
    checks++; if (bad_done !== 0) begin failures++; $display("FAIL div1_early_done bad=%0d exp=0", bad_done); end
    @(negedge clk);
    checks++; if (done_b !== 1'b0) begin failures++; $display("FAIL div1_pulse got=%b exp=0", done_b); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
